// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO master: FSM states, frame field
// constants and the frame builder used when a command is accepted.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    localparam int PRE_LEN   = 32;
    localparam int HDR_LEN   = 14;
    localparam int TA_LEN    = 2;
    localparam int FRAME_LEN = 64;

    // First bit index where a read releases the line (first TA bit)
    localparam int TA_START  = PRE_LEN + HDR_LEN;

    // Full 64-bit frame, MSB transmitted first. For reads the TA/DATA part is
    // filler: the line is released there, so the values never reach the pin.
    function automatic logic [63:0] build_frame(
        input logic        op,
        input logic [4:0]  phyad,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        build_frame = {32'hFFFF_FFFF, ST, (op ? OP_RD : OP_WR), phyad, regad,
                       (op ? 2'b11 : 2'b10), (op ? 16'hFFFF : wdata)};
    endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// MDC divider: low for CLK_DIV cycles then high for CLK_DIV cycles while
// enabled; held low with the counter cleared otherwise. The rise/fall strobes
// flag the clk edge on which mdc is about to change.
module mdc_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       half_end;

    assign half_end = en && (cnt == 8'(CLK_DIV - 1));
    assign rise     = half_end && !mdc;
    assign fall     = half_end && mdc;

    // Half-period counter; toggles mdc at the end of every half period
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            cnt <= 8'd0;
            mdc <= 1'b0;
        end else if (half_end) begin
            cnt <= 8'd0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: accepts one read/write command at a time, shifts out
// a 64-bit frame on mdc/mdio and returns read data with a one-cycle response.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);

    state_t      state, state_nxt;
    logic        accept;
    logic        mdc_rise, mdc_fall;
    logic        op_q;
    logic [5:0]  bit_cnt;
    logic [63:0] frame;
    logic [63:0] tx_sh;
    logic [15:0] rx_sh;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign frame     = build_frame(cmd_op, cmd_phyad, cmd_regad, cmd_wdata);

    mdc_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_mdc_gen (
        .clk    (clk),
        .resetn (resetn),
        .en     (busy),
        .mdc    (mdc),
        .rise   (mdc_rise),
        .fall   (mdc_fall)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next state: phases advance on the falling mdc edge ending their last bit
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_PREAMBLE;
            S_PREAMBLE: if (mdc_fall && bit_cnt == 6'(PRE_LEN - 1)) state_nxt = S_HEADER;
            S_HEADER:   if (mdc_fall && bit_cnt == 6'(TA_START - 1)) state_nxt = S_TA;
            S_TA:       if (mdc_fall && bit_cnt == 6'(TA_START + TA_LEN - 1)) state_nxt = S_DATA;
            S_DATA:     if (mdc_fall && bit_cnt == 6'(FRAME_LEN - 1)) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Frame shifter: bit 0 goes out on acceptance, later bits at each mdc fall;
    // read data is captured on the mdc rise of every DATA bit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mdio_o    <= 1'b1;
            mdio_t    <= 1'b1;
            rsp_rdata <= 16'h0000;
            bit_cnt   <= 6'd0;
            op_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op;
                tx_sh   <= {frame[62:0], 1'b1};
                mdio_o  <= frame[63];
                mdio_t  <= 1'b0;
                bit_cnt <= 6'd0;
            end else if (mdc_fall && busy) begin
                if (bit_cnt == 6'(FRAME_LEN - 1)) begin
                    mdio_o    <= 1'b1;
                    mdio_t    <= 1'b1;
                    rsp_rdata <= op_q ? rx_sh : 16'h0000;
                end else begin
                    mdio_o  <= tx_sh[63];
                    tx_sh   <= {tx_sh[62:0], 1'b1};
                    mdio_t  <= op_q && (bit_cnt >= 6'(TA_START - 1));
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
            if (mdc_rise && state == S_DATA) rx_sh <= {rx_sh[14:0], mdio_i};
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: directed and randomized frames on a CLK_DIV=4
// instance plus a no-PHY read on a CLK_DIV=2 instance.
module tb_mdio_master;

    localparam int DA = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        a_cmd_valid, a_cmd_ready, a_cmd_op;
    logic [4:0]  a_cmd_phyad, a_cmd_regad;
    logic [15:0] a_cmd_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_busy, a_mdc, a_mdio_o, a_mdio_t;
    logic        a_mdio_i = 1'b1;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_op;
    logic [4:0]  b_cmd_phyad, b_cmd_regad;
    logic [15:0] b_cmd_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_busy, b_mdc, b_mdio_o, b_mdio_t;
    logic        b_mdio_i = 1'b1;

    mdio_master #(.CLK_DIV(DA)) u_a (
        .clk(clk), .resetn(resetn), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_op(a_cmd_op), .cmd_phyad(a_cmd_phyad), .cmd_regad(a_cmd_regad),
        .cmd_wdata(a_cmd_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .busy(a_busy), .mdc(a_mdc), .mdio_o(a_mdio_o), .mdio_t(a_mdio_t), .mdio_i(a_mdio_i)
    );

    mdio_master #(.CLK_DIV(DB)) u_b (
        .clk(clk), .resetn(resetn), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(b_cmd_op), .cmd_phyad(b_cmd_phyad), .cmd_regad(b_cmd_regad),
        .cmd_wdata(b_cmd_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .busy(b_busy), .mdc(b_mdc), .mdio_o(b_mdio_o), .mdio_t(b_mdio_t), .mdio_i(b_mdio_i)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Line monitor and PHY model for instance A: records mdio_o/mdio_t at each
    // mdc rise, flags any change while mdc is high, and drives read data so it
    // is settled a full bit ahead of the rise that samples it.
    logic [63:0] a_cap_o = '0, a_cap_t = '0;
    logic [15:0] a_phy_word = '0;
    logic        a_mdc_q = 1'b0, a_last_o = 1'b1, a_last_t = 1'b1;
    int          a_nbits = 0, a_stab_bad = 0;

    always @(negedge clk) begin
        if (a_busy !== 1'b1) begin
            a_nbits  = 0;
            a_mdio_i = 1'b1;
        end else if (a_mdc === 1'b1 && a_mdc_q === 1'b0) begin
            a_cap_o  = {a_cap_o[62:0], a_mdio_o};
            a_cap_t  = {a_cap_t[62:0], a_mdio_t};
            a_last_o = a_mdio_o;
            a_last_t = a_mdio_t;
            a_nbits++;
            if (a_nbits >= 48 && a_nbits <= 63) a_mdio_i = a_phy_word[63 - a_nbits];
            else                                a_mdio_i = 1'b1;
        end else if (a_mdc === 1'b1 && (a_mdio_o !== a_last_o || a_mdio_t !== a_last_t)) begin
            a_stab_bad++;
        end
        a_mdc_q = a_mdc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the frame as the PHY should see it, MSB = first bit on the wire
    function automatic logic [63:0] ref_bits(input bit op, input logic [4:0] pa,
                                             input logic [4:0] ra, input logic [15:0] wd);
        if (op) ref_bits = {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 18'h0};
        else    ref_bits = {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd};
    endfunction

    // Released-line mask: a read leaves bits 46..63 to the PHY
    function automatic logic [63:0] ref_tmask(input bit op);
        ref_tmask = op ? 64'h0000_0000_0003_FFFF : 64'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    // Present a command at a negedge and take it through the acceptance edge
    task automatic accept_a(input string tag, input bit op, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] wd, input logic [15:0] phy);
        a_cmd_op = op; a_cmd_phyad = pa; a_cmd_regad = ra; a_cmd_wdata = wd;
        a_phy_word = phy;
        a_cmd_valid = 1'b1;
        check({tag, "_ready_before"}, 64'(a_cmd_ready), 64'd1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        check({tag, "_busy_after_accept"}, 64'({a_busy, a_cmd_ready}), 64'b10);
    endtask

    task automatic wait_rsp_a(input string tag, input bit scramble);
        while (a_rsp_valid !== 1'b1 && n < 2000) begin
            if (scramble) begin
                a_cmd_valid = 1'($urandom);
                a_cmd_op    = 1'($urandom);
                a_cmd_phyad = 5'($urandom);
                a_cmd_regad = 5'($urandom);
                a_cmd_wdata = 16'($urandom);
            end
            tick();
        end
        check({tag, "_rsp_seen"}, 64'(a_rsp_valid), 64'd1);
    endtask

    task automatic check_frame_a(input string tag, input bit op, input logic [4:0] pa,
                                 input logic [4:0] ra, input logic [15:0] wd, input logic [15:0] phy);
        logic [63:0] tm;
        logic [63:0] exp;
        tm  = ref_tmask(op);
        exp = ref_bits(op, pa, ra, wd);
        check({tag, "_latency"}, 64'(n), 64'(128 * DA + 1));
        check({tag, "_nbits"}, 64'(a_nbits), 64'd64);
        check({tag, "_mdio_o"}, a_cap_o & ~tm, exp & ~tm);
        check({tag, "_mdio_t"}, a_cap_t, tm);
        check({tag, "_rdata"}, 64'(a_rsp_rdata), 64'(op ? phy : 16'h0000));
        check({tag, "_done_lines"}, 64'({a_mdc, a_mdio_t}), 64'b01);
        check({tag, "_stable_high"}, 64'(a_stab_bad), 64'd0);
    endtask

    task automatic post_a(input string tag, input logic [15:0] rd);
        a_cmd_valid = 1'b0;
        tick();
        check({tag, "_post"}, 64'({a_cmd_ready, a_busy, a_rsp_valid}), 64'b100);
        check({tag, "_rdata_hold"}, 64'(a_rsp_rdata), 64'(rd));
    endtask

    bit          r_op;
    logic [4:0]  r_pa, r_ra;
    logic [15:0] r_wd, r_phy;
    bit          s_op;
    logic [4:0]  s_pa, s_ra;
    logic [15:0] s_wd, s_phy;
    int          rsp_cnt, ready_n, rises, highs, last_rise, per_bad;
    logic        mq;

    initial begin
        resetn = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_op = 1'b0; a_cmd_phyad = '0; a_cmd_regad = '0; a_cmd_wdata = '0;
        b_cmd_valid = 1'b0; b_cmd_op = 1'b0; b_cmd_phyad = '0; b_cmd_regad = '0; b_cmd_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("reset_ctrl", 64'({a_cmd_ready, a_busy, a_rsp_valid}), 64'b100);
        check("reset_lines", 64'({a_mdc, a_mdio_o, a_mdio_t}), 64'b011);
        check("reset_rdata", 64'(a_rsp_rdata), 64'h0);

        // Directed write from the example frame
        accept_a("wr0", 1'b0, 5'h07, 5'h00, 16'h1140, 16'h0);
        a_cmd_valid = 1'b0;
        wait_rsp_a("wr0", 1'b0);
        check_frame_a("wr0", 1'b0, 5'h07, 5'h00, 16'h1140, 16'h0);
        check("wr0_literal", a_cap_o, 64'hFFFF_FFFF_5382_1140);
        post_a("wr0", 16'h0000);

        // Directed read with a responding PHY
        accept_a("rd0", 1'b1, 5'h01, 5'h02, 16'h0, 16'hABCD);
        a_cmd_valid = 1'b0;
        wait_rsp_a("rd0", 1'b0);
        check_frame_a("rd0", 1'b1, 5'h01, 5'h02, 16'h0, 16'hABCD);
        post_a("rd0", 16'hABCD);

        // Randomized commands; odd ones also churn every cmd_* input while busy
        for (int i = 0; i < 6; i++) begin
            r_op = 1'($urandom); r_pa = 5'($urandom); r_ra = 5'($urandom);
            r_wd = 16'($urandom); r_phy = 16'($urandom);
            accept_a($sformatf("rnd%0d", i), r_op, r_pa, r_ra, r_wd, r_phy);
            a_cmd_valid = 1'b0;
            wait_rsp_a($sformatf("rnd%0d", i), (i % 2) == 1);
            check_frame_a($sformatf("rnd%0d", i), r_op, r_pa, r_ra, r_wd, r_phy);
            post_a($sformatf("rnd%0d", i), r_op ? r_phy : 16'h0000);
        end

        // Back-to-back: cmd_valid stays high across a write followed by a read
        r_pa = 5'($urandom); r_ra = 5'($urandom); r_wd = 16'($urandom);
        s_op = 1'b1; s_pa = 5'($urandom); s_ra = 5'($urandom); s_wd = 16'($urandom);
        s_phy = 16'($urandom_range(1, 65535));
        rsp_cnt = 0;
        accept_a("b2b1", 1'b0, r_pa, r_ra, r_wd, s_phy);
        a_cmd_op = s_op; a_cmd_phyad = s_pa; a_cmd_regad = s_ra; a_cmd_wdata = s_wd;
        while (a_cmd_ready !== 1'b1 && n < 2000) begin
            if (a_rsp_valid === 1'b1) begin
                rsp_cnt++;
                check_frame_a("b2b1", 1'b0, r_pa, r_ra, r_wd, 16'h0);
            end
            tick();
        end
        ready_n = n;
        check("b2b_second_accept_cycle", 64'(ready_n), 64'(128 * DA + 2));
        @(posedge clk);
        n = 1;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        wait_rsp_a("b2b2", 1'b0);
        rsp_cnt++;
        check_frame_a("b2b2", s_op, s_pa, s_ra, s_wd, s_phy);
        post_a("b2b2", s_phy);
        repeat (20) tick();
        check("b2b_rsp_count", 64'(rsp_cnt), 64'd2);
        check("b2b_no_extra", 64'({a_busy, a_cmd_ready}), 64'b01);

        // Reset in the middle of a write
        accept_a("rst", 1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0);
        a_cmd_valid = 1'b0;
        while (n < 200) tick();
        resetn = 1'b0;
        tick();
        check("rst_lines", 64'({a_mdc, a_mdio_o, a_mdio_t}), 64'b011);
        check("rst_ctrl", 64'({a_busy, a_rsp_valid}), 64'b00);
        check("rst_rdata", 64'(a_rsp_rdata), 64'h0);
        resetn = 1'b1;
        tick();
        check("rst_ready_after_release", 64'(a_cmd_ready), 64'd1);
        rsp_cnt = 0;
        repeat (600) begin
            if (a_rsp_valid === 1'b1) rsp_cnt++;
            tick();
        end
        check("rst_no_rsp", 64'(rsp_cnt), 64'd0);
        r_pa = 5'($urandom); r_ra = 5'($urandom); r_wd = 16'($urandom);
        accept_a("rst_new", 1'b0, r_pa, r_ra, r_wd, 16'h0);
        a_cmd_valid = 1'b0;
        wait_rsp_a("rst_new", 1'b0);
        check_frame_a("rst_new", 1'b0, r_pa, r_ra, r_wd, 16'h0);
        post_a("rst_new", 16'h0000);

        // CLK_DIV=2 read with nothing answering (pull-up keeps mdio_i at 1)
        b_cmd_op = 1'b1; b_cmd_phyad = 5'h03; b_cmd_regad = 5'h01; b_cmd_valid = 1'b1;
        check("b_ready_before", 64'(b_cmd_ready), 64'd1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        rises = 0; highs = 0; last_rise = 0; per_bad = 0; mq = 1'b0;
        while (b_rsp_valid !== 1'b1 && n < 1000) begin
            if (b_mdc === 1'b1) highs++;
            if (b_mdc === 1'b1 && mq === 1'b0) begin
                if (rises > 0 && (n - last_rise) != 2 * DB) per_bad++;
                rises++;
                last_rise = n;
            end
            mq = b_mdc;
            tick();
        end
        check("b_latency", 64'(n), 64'(128 * DB + 1));
        check("b_rises", 64'(rises), 64'd64);
        check("b_high_cycles", 64'(highs), 64'(64 * DB));
        check("b_period", 64'(per_bad), 64'd0);
        check("b_rdata", 64'(b_rsp_rdata), 64'hFFFF);
        tick();
        check("b_idle", 64'({b_cmd_ready, b_busy, b_mdc, b_mdio_o, b_mdio_t}), 64'b10011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
